// File: rtl/fsmc_fifo_pkg.sv
// Shared constants and types for the FSMC host port / dual stream FIFO block.
// Defines the default FIFO depth, the access FSM encoding, and the status/control word bit positions.
package fsmc_fifo_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int DW        = 16;

  typedef enum logic [1:0] {
    ACC_IDLE = 2'd0,
    ACC_DATA = 2'd1,
    ACC_STAT = 2'd2
  } acc_state_e;

  // Status word: {ovf, udf, h2f_count[5:0], 2'b00, f2h_count[5:0]}
  localparam int ST_OVF     = 15;
  localparam int ST_UDF     = 14;
  localparam int ST_H2F_CNT = 8;
  localparam int ST_F2H_CNT = 0;
  localparam int ST_CNT_W   = 6;

  localparam int CTL_FLUSH_H2F = 0;
  localparam int CTL_FLUSH_F2H = 1;
  localparam int CTL_CLR_ERR   = 15;

endpackage

// File: rtl/fsmc_fifo_port_if.sv
// Valid/ready stream used for both fabric-facing FIFO ports.
// The block is master on the H2F stream and slave on the F2H stream.
interface fsmc_fifo_port_if
  import fsmc_fifo_pkg::*;
();

  logic [DW-1:0] data;
  logic          valid;
  logic          ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/fsmc_fifo_port_sync_fifo.sv
// Single-clock FIFO with occupancy count.
// flush empties the FIFO and overrides any push or pop in the same cycle.
module sync_fifo
  import fsmc_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_ok  = pop & ~empty;
  // A push into a full FIFO is still accepted when a pop frees a slot this cycle.
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush && !reset) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fsmc_fifo_port.sv
// FSMC host port bridging chip-select accesses to an H2F and an F2H stream FIFO.
// Each access commits exactly one action on the falling edge of its select.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no access open; waiting for a clean rise of en or en_stat
// DATA     | data-port access open; push H2F or pop F2H on fall of en
// STAT     | status-port access open; control write commits on fall
module fsmc_fifo_port
  import fsmc_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    en_stat,
  input  logic                    state,
  input  logic [DW-1:0]           wr_data,
  output logic [DW-1:0]           rd_data,
  fsmc_fifo_port_if.master        m,
  fsmc_fifo_port_if.slave         s,
  output logic                    ovf_err,
  output logic                    udf_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [1:0] S_IDLE = ACC_IDLE;
  localparam logic [1:0] S_DATA = ACC_DATA;
  localparam logic [1:0] S_STAT = ACC_STAT;

  logic [1:0]    acc_st;
  logic          acc_dir;
  logic          f2h_empty_start;
  logic          en_q;
  logic          stat_q;
  logic          en_armed;
  logic          stat_armed;
  logic          rise_en;
  logic          rise_stat;
  logic          fall_en;
  logic          fall_stat;

  logic          data_commit;
  logic          stat_commit;
  logic          h2f_push;
  logic          h2f_pop;
  logic          h2f_flush;
  logic          f2h_push;
  logic          f2h_pop;
  logic          f2h_flush;
  logic          ovf_set;
  logic          udf_set;
  logic          err_clr;

  logic [DW-1:0] h2f_head;
  logic [DW-1:0] f2h_head;
  logic [CW-1:0] h2f_count;
  logic [CW-1:0] f2h_count;
  logic          h2f_full;
  logic          h2f_empty;
  logic          f2h_full;
  logic          f2h_empty;
  logic [DW-1:0] status;
  logic [DW-1:0] rd_next;

  // A select held high through reset is not armed until seen low, so a
  // leftover access cannot produce a spurious rise once reset releases.
  assign rise_en   = en & ~en_q & en_armed;
  assign rise_stat = en_stat & ~stat_q & stat_armed;
  assign fall_en   = ~en & en_q;
  assign fall_stat = ~en_stat & stat_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q            <= 1'b0;
      stat_q          <= 1'b0;
      en_armed        <= ~en;
      stat_armed      <= ~en_stat;
      acc_st          <= S_IDLE;
      acc_dir         <= 1'b0;
      f2h_empty_start <= 1'b0;
    end else begin
      en_q   <= en;
      stat_q <= en_stat;
      if (!en)      en_armed   <= 1'b1;
      if (!en_stat) stat_armed <= 1'b1;
      case (acc_st)
        S_IDLE: begin
          if (rise_en && !rise_stat) begin
            acc_st          <= S_DATA;
            acc_dir         <= state;
            f2h_empty_start <= f2h_empty;
          end else if (rise_stat && !rise_en) begin
            acc_st  <= S_STAT;
            acc_dir <= state;
          end
        end
        S_DATA:  if (fall_en)   acc_st <= S_IDLE;
        S_STAT:  if (fall_stat) acc_st <= S_IDLE;
        default: acc_st <= S_IDLE;
      endcase
    end
  end

  assign data_commit = (acc_st == S_DATA) & fall_en;
  assign stat_commit = (acc_st == S_STAT) & fall_stat & ~acc_dir;

  assign h2f_push  = data_commit & ~acc_dir;
  assign h2f_pop   = m.valid & m.ready;
  assign h2f_flush = stat_commit & wr_data[CTL_FLUSH_H2F];

  // A read that opened on an empty F2H never pops, even if data arrived since.
  assign f2h_pop   = data_commit & acc_dir & ~f2h_empty_start;
  assign f2h_push  = s.valid & s.ready;
  assign f2h_flush = stat_commit & wr_data[CTL_FLUSH_F2H];

  assign ovf_set = h2f_push & h2f_full & ~h2f_pop;
  assign udf_set = data_commit & acc_dir & f2h_empty_start;
  assign err_clr = stat_commit & wr_data[CTL_CLR_ERR];

  sync_fifo #(.DEPTH(DEPTH)) u_h2f (
    .clk   (clk),
    .reset (reset),
    .push  (h2f_push),
    .pop   (h2f_pop),
    .flush (h2f_flush),
    .din   (wr_data),
    .head  (h2f_head),
    .count (h2f_count),
    .full  (h2f_full),
    .empty (h2f_empty)
  );

  sync_fifo #(.DEPTH(DEPTH)) u_f2h (
    .clk   (clk),
    .reset (reset),
    .push  (f2h_push),
    .pop   (f2h_pop),
    .flush (f2h_flush),
    .din   (s.data),
    .head  (f2h_head),
    .count (f2h_count),
    .full  (f2h_full),
    .empty (f2h_empty)
  );

  assign m.valid = ~h2f_empty;
  assign m.data  = h2f_head;
  assign s.ready = ~f2h_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (ovf_set)      ovf_err <= 1'b1;
      else if (err_clr) ovf_err <= 1'b0;
      if (udf_set)      udf_err <= 1'b1;
      else if (err_clr) udf_err <= 1'b0;
    end
  end

  always_comb begin
    status = '0;
    status[ST_OVF] = ovf_err;
    status[ST_UDF] = udf_err;
    status[ST_H2F_CNT +: ST_CNT_W] = ST_CNT_W'(h2f_count);
    status[ST_F2H_CNT +: ST_CNT_W] = ST_CNT_W'(f2h_count);
  end

  always_comb begin
    rd_next = '0;
    if (acc_st == S_DATA && acc_dir) rd_next = f2h_empty ? '0 : f2h_head;
    else if (acc_st == S_STAT)       rd_next = status;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= rd_next;
  end

endmodule

// File: tb/tb_fsmc_fifo_port.sv
// Directed bench for fsmc_fifo_port (DEPTH=16) with hand-computed expected values.
module tb_fsmc_fifo_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        en_stat;
  logic        state;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        ovf_err;
  logic        udf_err;
  logic [15:0] rv;

  int n_assert = 0;
  int n_fail   = 0;

  fsmc_fifo_port_if m_if ();
  fsmc_fifo_port_if s_if ();

  fsmc_fifo_port #(.DEPTH(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .en_stat (en_stat),
    .state   (state),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .m       (m_if),
    .s       (s_if),
    .ovf_err (ovf_err),
    .udf_err (udf_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic stat, input logic [15:0] val);
    wr_data = val;
    state   = 1'b0;
    if (stat) en_stat = 1'b1; else en = 1'b1;
    tick();
    tick();
    en = 1'b0;
    en_stat = 1'b0;
    tick();
  endtask

  task automatic host_read(input logic stat, output logic [15:0] val);
    state = 1'b1;
    if (stat) en_stat = 1'b1; else en = 1'b1;
    tick();
    tick();
    val = rd_data;
    en = 1'b0;
    en_stat = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; en_stat = 1'b0; state = 1'b0; wr_data = '0;
    m_if.ready = 1'b0; s_if.valid = 1'b0; s_if.data = '0;
    tick();
    tick();
    chk("rst_rd_data", rd_data, 16'h0000);
    chk("rst_m_valid", {15'd0, m_if.valid}, 16'd0);
    chk("rst_s_ready", {15'd0, s_if.ready}, 16'd1);
    chk("rst_errs", {14'd0, ovf_err, udf_err}, 16'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_m_valid", {15'd0, m_if.valid}, 16'd0);
    chk("post_rst_s_ready", {15'd0, s_if.ready}, 16'd1);

    // H2F ordering with back-pressure
    host_write(1'b0, 16'h1234);
    chk("h2f_valid_after_commit", {15'd0, m_if.valid}, 16'd1);
    host_write(1'b0, 16'hABCD);
    host_read(1'b1, rv);
    chk("stat_two_h2f", rv, 16'h0200);
    chk("h2f_head0", m_if.data, 16'h1234);
    m_if.ready = 1'b1;
    tick();
    chk("h2f_head1", m_if.data, 16'hABCD);
    chk("h2f_valid_mid", {15'd0, m_if.valid}, 16'd1);
    tick();
    chk("h2f_valid_drop", {15'd0, m_if.valid}, 16'd0);
    m_if.ready = 1'b0;

    // F2H fill to full then drain in order
    s_if.valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_if.data = 16'(i);
      tick();
    end
    s_if.valid = 1'b0;
    chk("f2h_full_ready", {15'd0, s_if.ready}, 16'd0);
    for (int i = 1; i <= 16; i++) begin
      host_read(1'b0, rv);
      chk($sformatf("f2h_rd%0d", i), rv, 16'(i));
    end
    chk("f2h_ready_again", {15'd0, s_if.ready}, 16'd1);
    host_read(1'b1, rv);
    chk("stat_after_drain", rv, 16'h0000);

    // H2F overflow and error clear
    for (int i = 1; i <= 16; i++) host_write(1'b0, 16'h0100 + 16'(i));
    chk("h2f_full_no_ovf", {15'd0, ovf_err}, 16'd0);
    host_write(1'b0, 16'h5555);
    chk("ovf_set", {15'd0, ovf_err}, 16'd1);
    host_read(1'b1, rv);
    chk("stat_ovf", rv, 16'h9000);
    chk("ovf_head_kept", m_if.data, 16'h0101);
    host_write(1'b1, 16'h8000);
    chk("ovf_clear", {15'd0, ovf_err}, 16'd0);
    host_read(1'b1, rv);
    chk("stat_ovf_cleared", rv, 16'h1000);

    // F2H underflow, then simultaneous push and host pop
    host_read(1'b0, rv);
    chk("udf_rd_data", rv, 16'h0000);
    chk("udf_set", {15'd0, udf_err}, 16'd1);
    host_read(1'b1, rv);
    chk("stat_udf", rv, 16'h5000);
    s_if.valid = 1'b1;
    s_if.data = 16'h00A1;
    tick();
    s_if.data = 16'h00A2;
    tick();
    s_if.valid = 1'b0;
    state = 1'b1; en = 1'b1;
    tick();
    tick();
    chk("f2h_same_cycle_rd", rd_data, 16'h00A1);
    en = 1'b0; s_if.valid = 1'b1; s_if.data = 16'h00A3;
    tick();
    s_if.valid = 1'b0;
    host_read(1'b1, rv);
    chk("stat_push_pop_same", rv, 16'h5002);

    // Flush both FIFOs while a fabric pop and push are also requested
    state = 1'b0; wr_data = 16'h0003; en_stat = 1'b1;
    tick();
    tick();
    en_stat = 1'b0; m_if.ready = 1'b1; s_if.valid = 1'b1; s_if.data = 16'h0BAD;
    tick();
    m_if.ready = 1'b0; s_if.valid = 1'b0;
    chk("flush_m_valid", {15'd0, m_if.valid}, 16'd0);
    host_read(1'b1, rv);
    chk("stat_after_flush", rv, 16'h4000);
    host_write(1'b1, 16'h8000);
    chk("udf_clear", {15'd0, udf_err}, 16'd0);

    // Reset in the middle of a data write
    host_write(1'b0, 16'h6666);
    chk("pre_rst_word", m_if.data, 16'h6666);
    state = 1'b0; wr_data = 16'h7777; en = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("midrst_m_valid", {15'd0, m_if.valid}, 16'd0);
    en = 1'b0;
    tick();
    tick();
    chk("midrst_no_push", {15'd0, m_if.valid}, 16'd0);
    host_read(1'b1, rv);
    chk("midrst_stat", rv, 16'h0000);
    host_write(1'b0, 16'h2468);
    chk("post_midrst_write", m_if.data, 16'h2468);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
